// File: rtl/piano_pkg.sv
// piano_pkg: shared widths, mode indices, arbiter state type and a one-hot test
package piano_pkg;
  localparam int NOTE_W = 4;
  localparam int OCT_W = 2;
  localparam int LED_W = 7;
  localparam int NUM_W = 4;
  localparam int MODE_FREE = 0;
  localparam int MODE_AUTO = 1;
  localparam int MODE_LEARN = 2;
  localparam int MODE_PLAYBACK = 3;
  typedef enum logic [1:0] {IDLE, MUTE, ACTIVE, INVALID} arb_state_e;
  function automatic logic is_onehot(input logic [31:0] v);
    return v != 32'd0 && (v & (v - 32'd1)) == 32'd0;
  endfunction
endpackage

// File: rtl/start_toggle.sv
// start_toggle: play/pause flag that flips on each rising edge of start while enabled
//   clk, reset (sync, active-low), start (debounced level),
//   en (toggles allowed), clear (force flag to 0, wins over a toggle),
//   play_state (flag out)
module start_toggle (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic en,
  input  logic clear,
  output logic play_state
);
  logic start_q, start_d;
  logic play_q, play_d;
  always_comb begin
    start_d = start;
    play_d = clear ? 1'b0 : (en && start && !start_q) ? !play_q : play_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      start_q <= 1'b0;
      play_q <= 1'b0;
    end else begin
      start_q <= start_d;
      play_q <= play_d;
    end
  end
  assign play_state = play_q;
endmodule

// File: rtl/mode_arbiter.sv
// mode_arbiter: picks which mode engine drives the shared note/octave/LED/number outputs
//   clk, reset (sync, active-low), mode_sel (one-hot request), start (play/pause level),
//   src_note/src_oct/src_led/src_num (packed per-source buses, slice i = source i),
//   override_req (per-source pre-emption), note_out/octave_out/led_out/num_out (registered data),
//   play_state, active_mode (one-hot, 0 when silent), mode_err (mode_sel not one-hot)
module mode_arbiter
  import piano_pkg::*;
#(
  parameter int NUM_MODES = 4,
  parameter int NOTE_W = piano_pkg::NOTE_W,
  parameter int OCT_W = piano_pkg::OCT_W,
  parameter int LED_W = piano_pkg::LED_W,
  parameter int NUM_W = piano_pkg::NUM_W,
  parameter int MUTE_CYCLES = 1000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_MODES-1:0]        mode_sel,
  input  logic                        start,
  input  logic [NUM_MODES*NOTE_W-1:0] src_note,
  input  logic [NUM_MODES*OCT_W-1:0]  src_oct,
  input  logic [NUM_MODES*LED_W-1:0]  src_led,
  input  logic [NUM_MODES*NUM_W-1:0]  src_num,
  input  logic [NUM_MODES-1:0]        override_req,
  output logic [NOTE_W-1:0]           note_out,
  output logic [OCT_W-1:0]            octave_out,
  output logic [LED_W-1:0]            led_out,
  output logic [NUM_W-1:0]            num_out,
  output logic                        play_state,
  output logic [NUM_MODES-1:0]        active_mode,
  output logic                        mode_err
);
  localparam int CW = MUTE_CYCLES > 1 ? $clog2(MUTE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MUTE_CYCLES - 1);
  arb_state_e state_q, state_d;
  logic [NUM_MODES-1:0] pending_q, pending_d, active_mode_q, active_mode_d, src_sel;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [OCT_W-1:0] oct_q, oct_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic mode_err_q, mode_err_d, sel_bad, live;
  always_comb begin
    state_d = state_q;
    pending_d = pending_q;
    cnt_d = cnt_q;
    sel_bad = !is_onehot(32'(mode_sel)) && |mode_sel;
    mode_err_d = sel_bad;
    if (sel_bad) state_d = INVALID;
    else if (mode_sel == '0) state_d = IDLE;
    // a fresh one-hot request, or a different one while muting/active, (re)starts the gap
    else if (state_q == IDLE || state_q == INVALID || mode_sel != pending_q) begin
      state_d = MUTE;
      pending_d = mode_sel;
      cnt_d = CNT_LOAD;
    end else if (state_q == MUTE) begin
      state_d = cnt_q == '0 ? ACTIVE : MUTE;
      cnt_d = cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
    end
    // data only flows while staying in ACTIVE, so any mode change silences the next cycle
    live = state_q == ACTIVE && state_d == ACTIVE;
    // lowest requesting override wins; x & -x isolates the lowest set bit
    src_sel = |override_req ? override_req & (-override_req) : pending_q;
    active_mode_d = state_d == ACTIVE ? pending_d : '0;
    note_d = '0;
    oct_d = '0;
    led_d = '0;
    num_d = '0;
    for (int i = 0; i < NUM_MODES; i++) begin
      if (live && src_sel[i]) begin
        note_d = note_d | src_note[i*NOTE_W +: NOTE_W];
        oct_d = oct_d | src_oct[i*OCT_W +: OCT_W];
        led_d = led_d | src_led[i*LED_W +: LED_W];
        num_d = num_d | src_num[i*NUM_W +: NUM_W];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pending_q <= '0;
      cnt_q <= '0;
      active_mode_q <= '0;
      mode_err_q <= 1'b0;
      note_q <= '0;
      oct_q <= '0;
      led_q <= '0;
      num_q <= '0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      cnt_q <= cnt_d;
      active_mode_q <= active_mode_d;
      mode_err_q <= mode_err_d;
      note_q <= note_d;
      oct_q <= oct_d;
      led_q <= led_d;
      num_q <= num_d;
    end
  end
  start_toggle u_start_toggle (
    .clk(clk),
    .reset(reset),
    .start(start),
    .en(state_q == ACTIVE),
    .clear(state_d != ACTIVE),
    .play_state(play_state)
  );
  assign note_out = note_q;
  assign octave_out = oct_q;
  assign led_out = led_q;
  assign num_out = num_q;
  assign active_mode = active_mode_q;
  assign mode_err = mode_err_q;
endmodule

// File: tb/tb_mode_arbiter.sv
// tb_mode_arbiter: directed stimulus, per-cycle model comparison plus literal pins
module tb_mode_arbiter;
  localparam int N = 4;
  localparam int MC = 4;
  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] mode_sel, override_req;
  logic start;
  logic [N*4-1:0] src_note;
  logic [N*2-1:0] src_oct;
  logic [N*7-1:0] src_led;
  logic [N*4-1:0] src_num;
  logic [3:0] note_out, num_out;
  logic [1:0] octave_out;
  logic [6:0] led_out;
  logic play_state, mode_err;
  logic [N-1:0] active_mode;
  int n_chk = 0, n_pass = 0;
  logic chk_en = 1'b0;
  int m_src, m_mute;
  logic m_live, m_ps, m_start, was_live, out_live;
  logic [3:0] e_note, e_num;
  logic [1:0] e_oct;
  logic [6:0] e_led;
  logic [N-1:0] e_act;
  logic e_err;

  mode_arbiter #(.NUM_MODES(N), .MUTE_CYCLES(MC)) dut (
    .clk(clk), .reset(reset), .mode_sel(mode_sel), .start(start),
    .src_note(src_note), .src_oct(src_oct), .src_led(src_led), .src_num(src_num),
    .override_req(override_req), .note_out(note_out), .octave_out(octave_out),
    .led_out(led_out), .num_out(num_out), .play_state(play_state),
    .active_mode(active_mode), .mode_err(mode_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  // Reference: a selection is either silent, counting down a mute gap, or live;
  // data appears only on cycles where it was already live and remains live.
  always @(posedge clk) begin
    if (!reset) begin
      m_src = -1; m_mute = 0; m_live = 0; m_ps = 0; m_start = 0;
      e_note = 0; e_oct = 0; e_led = 0; e_num = 0; e_act = 0; e_err = 0;
    end else begin
      int k;
      was_live = m_live;
      if ($countones(mode_sel) != 1) begin
        m_src = -1; m_mute = 0; m_live = 0;
      end else if (m_src != $clog2(mode_sel)) begin
        m_src = $clog2(mode_sel); m_mute = MC; m_live = 0;
      end else if (m_mute > 0) begin
        m_mute--; m_live = (m_mute == 0);
      end
      k = m_src;
      for (int i = N - 1; i >= 0; i--) if (override_req[i]) k = i;
      out_live = was_live && m_live;
      e_note = out_live ? src_note[k*4 +: 4] : 4'h0;
      e_oct = out_live ? src_oct[k*2 +: 2] : 2'h0;
      e_led = out_live ? src_led[k*7 +: 7] : 7'h0;
      e_num = out_live ? src_num[k*4 +: 4] : 4'h0;
      e_act = m_live ? N'(1 << m_src) : '0;
      e_err = $countones(mode_sel) > 1;
      if (!m_live) m_ps = 0;
      else if (was_live && start && !m_start) m_ps = !m_ps;
      m_start = start;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("note", 32'(note_out), 32'(e_note));
      chk("octave", 32'(octave_out), 32'(e_oct));
      chk("led", 32'(led_out), 32'(e_led));
      chk("num", 32'(num_out), 32'(e_num));
      chk("active_mode", 32'(active_mode), 32'(e_act));
      chk("mode_err", 32'(mode_err), 32'(e_err));
      chk("play_state", 32'(play_state), 32'(m_ps));
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; mode_sel = '0; start = 1'b0; override_req = '0;
    src_note = {4'hD, 4'h9, 4'h5, 4'h1};
    src_oct = {2'd3, 2'd2, 2'd1, 2'd0};
    src_led = {7'h44, 7'h33, 7'h22, 7'h11};
    src_num = {4'h8, 4'h7, 4'h6, 4'h5};
    wait_n(3);
    chk_en = 1'b1;
    chk("pin_rst_note", 32'(note_out), 32'h0);
    chk("pin_rst_act", 32'(active_mode), 32'h0);
    chk("pin_rst_err", 32'(mode_err), 32'h0);
    chk("pin_rst_play", 32'(play_state), 32'h0);
    reset = 1'b1;
    wait_n(2);
    mode_sel = 4'b0010;
    wait_n(5);
    chk("pin_mute_note", 32'(note_out), 32'h0);
    chk("pin_act1", 32'(active_mode), 32'b0010);
    wait_n(1);
    chk("pin_slice1", 32'(note_out), 32'h5);
    start = 1'b1;
    wait_n(10);
    chk("pin_hold_toggle", 32'(play_state), 32'h1);
    start = 1'b0;
    wait_n(2);
    start = 1'b1;
    wait_n(3);
    chk("pin_second_press", 32'(play_state), 32'h0);
    start = 1'b0;
    wait_n(2);
    mode_sel = 4'b0110;
    wait_n(1);
    chk("pin_err", 32'(mode_err), 32'h1);
    chk("pin_err_note", 32'(note_out), 32'h0);
    mode_sel = 4'b0100;
    wait_n(6);
    chk("pin_slice2", 32'(note_out), 32'h9);
    start = 1'b1;
    wait_n(2);
    chk("pin_press", 32'(play_state), 32'h1);
    start = 1'b0;
    wait_n(2);
    start = 1'b1;
    mode_sel = 4'b0001;
    wait_n(1);
    chk("pin_press_vs_mode", 32'(play_state), 32'h0);
    start = 1'b0;
    wait_n(6);
    chk("pin_slice0", 32'(note_out), 32'h1);
    override_req = 4'b1000;
    wait_n(1);
    chk("pin_override", 32'(note_out), 32'hD);
    wait_n(2);
    override_req = '0;
    wait_n(1);
    chk("pin_override_release", 32'(note_out), 32'h1);
    override_req = 4'b0001;
    wait_n(2);
    override_req = 4'b0110;
    wait_n(1);
    chk("pin_override_lowest", 32'(note_out), 32'h5);
    override_req = '0;
    wait_n(2);
    mode_sel = '0;
    wait_n(2);
    chk("pin_idle_act", 32'(active_mode), 32'h0);
    mode_sel = 4'b0001;
    wait_n(2);
    mode_sel = 4'b0010;
    wait_n(5);
    chk("pin_restart_note", 32'(note_out), 32'h0);
    wait_n(1);
    chk("pin_restart_slice1", 32'(note_out), 32'h5);
    mode_sel = 4'b1100;
    wait_n(1);
    chk("pin_err2", 32'(mode_err), 32'h1);
    mode_sel = '0;
    wait_n(2);
    mode_sel = 4'b1000;
    wait_n(3);
    reset = 1'b0;
    wait_n(1);
    chk("pin_midreset_act", 32'(active_mode), 32'h0);
    reset = 1'b1;
    wait_n(8);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
